// File: rtl/image_store_fanout_pkg.sv
// Shared definitions for the image_store_fanout video fan-out: entry layout, clog2 helper,
// and the packet-tracking state encoding used when IMAGE_STORE_FANOUT_MASK_EN is defined.
package image_store_pkg;

    localparam int DATA_LSB = 0;

    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int v = value - 1; v > 0; v = v >> 1) begin
            result++;
        end
        return result;
    endfunction

    // FIFO entry is {sop, eop, data}.
    function automatic int fifo_entry_w(input int data_width);
        return data_width + 2;
    endfunction

    function automatic int eop_bit(input int data_width);
        return data_width;
    endfunction

    function automatic int sop_bit(input int data_width);
        return data_width + 1;
    endfunction

    typedef enum logic {
        IDLE   = 1'b0,
        IN_PKT = 1'b1
    } pkt_state_e;

endpackage

// File: rtl/image_store_fanout_fifo.sv
// Single first-word-fall-through FIFO; one instance per fan-out output.
module image_store_fanout_fifo
    import image_store_pkg::*;
#(
    parameter int WIDTH = 12,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             pop,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty
);

    localparam int PTR_W = clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign rd_data = mem[rd_ptr];

    // NOTE: sequential state uses non-blocking assignments so every register samples
    // pre-edge values, regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            // NOTE: storage is reset here so the fall-through outputs read 0 after reset;
            // a plain RAM would normally be left unreset.
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= wr_data;
                wr_ptr      <= wr_ptr + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/image_store_fanout.sv
// N-way Avalon-ST video fan-out with a private FWFT FIFO per output.
// Define IMAGE_STORE_FANOUT_MASK_EN to add per-packet output masking via dout_enable.
module image_store_fanout
    import image_store_pkg::*;
#(
    parameter int DATA_WIDTH = 10,
    parameter int NUM_OUT    = 2,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [DATA_WIDTH-1:0]         din_data,
    input  logic                          din_valid,
    output logic                          din_ready,
    input  logic                          din_startofpacket,
    input  logic                          din_endofpacket,
`ifdef IMAGE_STORE_FANOUT_MASK_EN
    input  logic [NUM_OUT-1:0]            dout_enable,
`endif
    output logic [NUM_OUT*DATA_WIDTH-1:0] dout_data,
    output logic [NUM_OUT-1:0]            dout_valid,
    input  logic [NUM_OUT-1:0]            dout_ready,
    output logic [NUM_OUT-1:0]            dout_startofpacket,
    output logic [NUM_OUT-1:0]            dout_endofpacket
);

    localparam int ENTRY_W = fifo_entry_w(DATA_WIDTH);

    logic [NUM_OUT-1:0] part;
    logic [NUM_OUT-1:0] full;
    logic [NUM_OUT-1:0] push;
    logic               accept;
    logic [ENTRY_W-1:0] wr_entry;

`ifdef IMAGE_STORE_FANOUT_MASK_EN
    pkt_state_e         state;
    pkt_state_e         state_next;
    logic [NUM_OUT-1:0] mask_q;

    // A sop beat already steers by the new enable; it is qualified by sop alone so
    // din_ready stays independent of din_valid.
    assign part = din_startofpacket ? dout_enable : mask_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            mask_q <= '1;
        end else begin
            state <= state_next;
            if (accept && din_startofpacket) begin
                mask_q <= dout_enable;
            end
        end
    end

    always_comb begin
        // NOTE: default first, so no path through the case leaves state_next unassigned
        // and no latch is inferred.
        state_next = state;
        case (state)
            IDLE:    if (accept && din_startofpacket && !din_endofpacket) state_next = IN_PKT;
            IN_PKT:  if (accept && din_endofpacket) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end
`else
    assign part = '1;
`endif

    // Only occupancy gates ready; a same-cycle pop on a full FIFO does not bypass it.
    assign din_ready = &(~part | ~full);
    assign accept    = din_valid & din_ready;
    assign push      = {NUM_OUT{accept}} & part;
    assign wr_entry  = {din_startofpacket, din_endofpacket, din_data};

    for (genvar i = 0; i < NUM_OUT; i++) begin : g_out
        logic [ENTRY_W-1:0] rd_entry;
        logic               empty;

        image_store_fanout_fifo #(
            .WIDTH (ENTRY_W),
            .DEPTH (FIFO_DEPTH)
        ) u_fifo (
            .clk     (clk),
            .rst_n   (rst_n),
            .push    (push[i]),
            .wr_data (wr_entry),
            .pop     (dout_valid[i] & dout_ready[i]),
            .rd_data (rd_entry),
            .full    (full[i]),
            .empty   (empty)
        );

        assign dout_valid[i]                            = ~empty;
        assign dout_data[i*DATA_WIDTH +: DATA_WIDTH]    = rd_entry[DATA_LSB +: DATA_WIDTH];
        assign dout_endofpacket[i]                      = rd_entry[eop_bit(DATA_WIDTH)];
        assign dout_startofpacket[i]                    = rd_entry[sop_bit(DATA_WIDTH)];
    end

endmodule

// File: tb/tb_image_store_fanout.sv
// Scoreboard bench for image_store_fanout (NUM_OUT=2, FIFO_DEPTH=4); the mask scenario
// runs only when IMAGE_STORE_FANOUT_MASK_EN is defined.
module tb_image_store_fanout;

    localparam int DW    = 10;
    localparam int NO    = 2;
    localparam int DEPTH = 4;

    typedef logic [DW+1:0] entry_t;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [DW-1:0]    din_data;
    logic             din_valid;
    logic             din_ready;
    logic             din_startofpacket;
    logic             din_endofpacket;
    logic [NO*DW-1:0] dout_data;
    logic [NO-1:0]    dout_valid;
    logic [NO-1:0]    dout_ready;
    logic [NO-1:0]    dout_startofpacket;
    logic [NO-1:0]    dout_endofpacket;
`ifdef IMAGE_STORE_FANOUT_MASK_EN
    logic [NO-1:0]    dout_enable;
`endif

    entry_t        sb [NO][$];
    logic [NO-1:0] mask_m;
    int            checks = 0;
    int            passes = 0;
    int            fails  = 0;
    int            accepted;
    int            ready_lows;
    int            popped [NO];

    always #5 clk = ~clk;

    image_store_fanout #(
        .DATA_WIDTH (DW),
        .NUM_OUT    (NO),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clk                (clk),
        .rst_n              (rst_n),
        .din_data           (din_data),
        .din_valid          (din_valid),
        .din_ready          (din_ready),
        .din_startofpacket  (din_startofpacket),
        .din_endofpacket    (din_endofpacket),
`ifdef IMAGE_STORE_FANOUT_MASK_EN
        .dout_enable        (dout_enable),
`endif
        .dout_data          (dout_data),
        .dout_valid         (dout_valid),
        .dout_ready         (dout_ready),
        .dout_startofpacket (dout_startofpacket),
        .dout_endofpacket   (dout_endofpacket)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else begin
            fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [DW-1:0] d, input logic s, input logic e);
        din_valid         = v;
        din_data          = d;
        din_startofpacket = s;
        din_endofpacket   = e;
    endtask

    // One clock cycle: model ready, compare any output pops, record accepted beats.
    task automatic cycle();
        logic [NO-1:0] part;
        logic          exp_ready;
        entry_t        exp_e;
        entry_t        obs_e;
        #1;
        part = '1;
`ifdef IMAGE_STORE_FANOUT_MASK_EN
        part = din_startofpacket ? dout_enable : mask_m;
`endif
        exp_ready = 1'b1;
        for (int i = 0; i < NO; i++) begin
            if (part[i] && sb[i].size() >= DEPTH) exp_ready = 1'b0;
        end
        check("din_ready", din_ready, exp_ready);
        if (!din_ready) ready_lows++;
        for (int i = 0; i < NO; i++) begin
            check($sformatf("dout_valid[%0d]", i), dout_valid[i], sb[i].size() != 0);
            if (dout_valid[i] && dout_ready[i] && sb[i].size() != 0) begin
                exp_e = sb[i].pop_front();
                obs_e = {dout_startofpacket[i], dout_endofpacket[i], dout_data[i*DW +: DW]};
                check($sformatf("beat[%0d]", i), obs_e, exp_e);
                popped[i]++;
            end
        end
        if (din_valid && exp_ready) begin
            accepted++;
            for (int i = 0; i < NO; i++) begin
                if (part[i]) sb[i].push_back({din_startofpacket, din_endofpacket, din_data});
            end
`ifdef IMAGE_STORE_FANOUT_MASK_EN
            if (din_startofpacket) mask_m = dout_enable;
`endif
        end
        @(negedge clk);
    endtask

    task automatic clear_counts();
        accepted   = 0;
        ready_lows = 0;
        for (int i = 0; i < NO; i++) popped[i] = 0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n      = 1'b0;
        dout_ready = '0;
        mask_m     = '1;
        drive(1'b0, '0, 1'b0, 1'b0);
`ifdef IMAGE_STORE_FANOUT_MASK_EN
        dout_enable = '1;
`endif
        clear_counts();

        // Reset state
        #3;
        check("rst_dout_valid", dout_valid, 0);
        check("rst_dout_data", dout_data, 0);
        check("rst_dout_sop", dout_startofpacket, 0);
        check("rst_dout_eop", dout_endofpacket, 0);
        @(negedge clk);
        rst_n = 1'b1;
        cycle();

        // Lock-step: both outputs ready, 16-beat packet
        dout_ready = 2'b11;
        clear_counts();
        for (int k = 0; k < 16; k++) begin
            drive(1'b1, DW'(k), k == 0, k == 15);
            cycle();
        end
        drive(1'b0, '0, 1'b0, 1'b0);
        repeat (3) cycle();
        check("lockstep_ready_lows", ready_lows, 0);
        check("lockstep_popped0", popped[0], 16);
        check("lockstep_popped1", popped[1], 16);

        // Independent stall on output 1
        dout_ready = 2'b01;
        clear_counts();
        for (int k = 0; k < 8; k++) begin
            drive(1'b1, DW'(100 + accepted), accepted == 0, 1'b0);
            cycle();
        end
        check("stall_accepted", accepted, 4);
        check("stall_popped0", popped[0], 4);
        check("stall_popped1", popped[1], 0);

        // Full FIFO 1 popped while din_valid: ready stays low this cycle, rises next
        dout_ready = 2'b11;
        drive(1'b1, DW'(100 + accepted), 1'b0, 1'b0);
        #1 check("full_pop_ready_low", din_ready, 0);
        cycle();
        #1 check("after_pop_ready_high", din_ready, 1);
        cycle();
        drive(1'b1, DW'(100 + accepted), 1'b0, 1'b1);
        cycle();
        drive(1'b0, '0, 1'b0, 1'b0);
        repeat (8) cycle();
        check("stall_drain_popped0", popped[0], accepted);
        check("stall_drain_popped1", popped[1], accepted);
        check("stall_sb1_empty", sb[1].size(), 0);

        // Asynchronous reset mid-packet
        clear_counts();
        for (int k = 0; k < 3; k++) begin
            drive(1'b1, DW'(200 + k), k == 0, 1'b0);
            cycle();
        end
        drive(1'b0, '0, 1'b0, 1'b0);
        #1 check("pre_reset_valid", dout_valid, 2'b11);
        #2 rst_n = 1'b0;
        #1;
        check("async_reset_valid", dout_valid, 0);
        check("async_reset_data", dout_data, 0);
        for (int i = 0; i < NO; i++) sb[i].delete();
        mask_m = '1;
        @(negedge clk);
        rst_n = 1'b1;
        cycle();
        clear_counts();
        for (int k = 0; k < 4; k++) begin
            drive(1'b1, DW'(300 + k), k == 0, k == 3);
            cycle();
        end
        drive(1'b0, '0, 1'b0, 1'b0);
        repeat (3) cycle();
        check("post_reset_popped0", popped[0], 4);
        check("post_reset_popped1", popped[1], 4);

`ifdef IMAGE_STORE_FANOUT_MASK_EN
        // Mask: packet steered to output 0 only; mid-packet enable change ignored
        dout_ready  = 2'b01;
        dout_enable = 2'b01;
        clear_counts();
        for (int k = 0; k < 8; k++) begin
            if (k == 2) dout_enable = 2'b11;
            drive(1'b1, DW'(400 + k), k == 0, k == 7);
            cycle();
        end
        drive(1'b0, '0, 1'b0, 1'b0);
        repeat (3) cycle();
        check("mask_ready_lows", ready_lows, 0);
        check("mask_popped0", popped[0], 8);
        check("mask_out1_valid", dout_valid[1], 0);

        dout_ready = 2'b11;
        clear_counts();
        for (int k = 0; k < 4; k++) begin
            drive(1'b1, DW'(500 + k), k == 0, k == 3);
            cycle();
        end
        drive(1'b0, '0, 1'b0, 1'b0);
        repeat (3) cycle();
        check("mask_next_popped0", popped[0], 4);
        check("mask_next_popped1", popped[1], 4);
`endif

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/image_store_fanout.md
Name: image_store_fanout

Overview:
- Parametrised N-way Avalon-ST video fan-out. Each input beat (data, sop, eop) is copied to NUM_OUT output streams.
- Each output has its own small FWFT FIFO, so outputs drain independently. A stalled consumer blocks the source only when its own FIFO is full.
- Sits between a video source and multiple sinks (frame store, display, stats) that do not assert ready in lock-step.

Parameters:
- DATA_WIDTH, 10, pixel data width.
- NUM_OUT, 2, number of output streams, >= 1.
- FIFO_DEPTH, 4, entries per output FIFO, power of two, >= 2.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- din_data  in  DATA_WIDTH  input pixel.
- din_valid  in  1  input beat valid.
- din_ready  out  1  input may be accepted this cycle.
- din_startofpacket  in  1  first beat of packet.
- din_endofpacket  in  1  last beat of packet.
- dout_data  out  NUM_OUT*DATA_WIDTH  output i at [i*DATA_WIDTH +: DATA_WIDTH].
- dout_valid  out  NUM_OUT  per-output valid.
- dout_ready  in  NUM_OUT  per-output ready.
- dout_startofpacket  out  NUM_OUT  per-output sop.
- dout_endofpacket  out  NUM_OUT  per-output eop.

Behaviour:
- Clocking and reset:
  - One clock. Reset is asynchronous and active-low (rst_n). All state clears on assertion, independent of clk.
  - Reset mid-packet discards all buffered beats; no partial-packet recovery.
- Reset values:
  - All FIFO counts, read pointers and write pointers are 0.
  - dout_valid = 0. dout_data, dout_startofpacket and dout_endofpacket read 0 (storage is reset).
  - din_ready = 1 one cycle after reset release.
- FIFO entry: {sop, eop, data}, DATA_WIDTH+2 bits.
- Accept condition: accept = din_valid & din_ready. An accepted beat is written into every participating FIFO in the same edge.
- din_ready is combinational:
  - din_ready = AND over participating i of (count_i != FIFO_DEPTH).
  - A read on a full FIFO in the same cycle does NOT raise din_ready. There is no full-FIFO bypass, which keeps the ready path free of dout_ready.
- Output side:
  - dout_valid[i] = (count_i != 0). Data and flags come combinationally from mem_i[rd_ptr_i] (first-word fall-through).
  - pop_i = dout_valid[i] & dout_ready[i].
- Latency: a beat accepted at edge N is visible on every output from cycle N+1. There is no combinational din-to-dout path.
- Count update per FIFO:
  - push only: +1.
  - pop only: -1.
  - push and pop: unchanged.
  - Count width is clog2(FIFO_DEPTH)+1.
- Pointers are clog2(FIFO_DEPTH) bits and wrap naturally.
- Skew: outputs may differ by up to FIFO_DEPTH beats. Per-output beat order is always preserved, and sop/eop are never altered.
- Boundaries:
  - An empty FIFO with push and no pop becomes valid the next cycle.
  - A full FIFO with pop and no push frees one slot; din_ready may rise the next cycle.
  - NUM_OUT = 1 degenerates to a single FWFT FIFO.
- din_ready does not depend on din_valid (Avalon-ST ready latency 0).

Optional Feature:
- Macro: IMAGE_STORE_FANOUT_MASK_EN.
- Defined:
  - Adds port dout_enable, in, NUM_OUT bits.
  - Adds a packet-tracking FSM: IDLE / IN_PKT.
    - IDLE -> IN_PKT on an accepted beat with sop=1 and eop=0.
    - IN_PKT -> IDLE on an accepted beat with eop=1.
    - An accepted sop&eop beat stays in IDLE.
  - mask_q latches dout_enable on every accepted sop beat, and that same beat already uses the new mask.
  - Participating set = mask_q, or dout_enable on the sop beat.
  - Masked outputs neither receive beats nor gate din_ready.
  - If no output is enabled, din_ready = 1 and beats are discarded.
  - Changes to dout_enable mid-packet are ignored until the next sop.
  - Reset value of mask_q is all ones.
- Not defined: no port, no FSM. All outputs always participate.

Decomposition:
- Package image_store_pkg holds:
  - FIFO_ENTRY_W = DATA_WIDTH+2.
  - Entry field offsets: DATA_LSB = 0, EOP_BIT = DATA_WIDTH, SOP_BIT = DATA_WIDTH+1.
  - A clog2 function.
  - The FSM state encoding: IDLE = 1'b0, IN_PKT = 1'b1.
- Sub-module image_store_fanout_fifo: single FWFT FIFO with push/pop/full/empty. It is generated NUM_OUT times. The top level holds the ready AND-reduction and the optional mask FSM.

Test Plan:
- Lock-step: NUM_OUT=2, all dout_ready=1, 16-beat packet 0..15 with sop on 0 and eop on 15 -> both outputs emit 0..15 starting one cycle after each accept, din_ready is never low.
- Independent stall: dout_ready[1]=0, dout_ready[0]=1, continuous input -> output 0 drains; din_ready drops after exactly 4 accepted beats. Then release dout_ready[1] -> output 1 emits beats 0..3 in order, and din_ready rises the cycle after the first pop.
- Full plus simultaneous pop: FIFO 1 full, pop on FIFO 1 and din_valid=1 in the same cycle -> din_ready stays 0 that cycle and is 1 the next.
- Async reset mid-packet: assert rst_n low between edges after 3 beats -> dout_valid goes to 0 immediately. After release, a new packet emerges with no stale beats.
- Mask (IMAGE_STORE_FANOUT_MASK_EN): dout_enable=2'b01 at sop, dout_ready[1]=0, then dout_enable set to 2'b11 mid-packet -> the entire packet flows to output 0 only, with no back-pressure from output 1. The next packet goes to both outputs.
